sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one sevenseg BCD-to-segment decoder across NDIG common-anode digit positions.
- Holds a double-buffered set of NDIG BCD nibbles, loaded through a valid/ready handshake.
- Steps through the digits at a fixed slot rate, driving the decoder's 4-bit data input and a one-hot digit-enable bus.
- Commits new values only at frame boundaries, so a frame never shows a mix of old and new digits.
- Inserts a blanking gap at the start of each slot to suppress ghosting.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
DIV, 1000, clock cycles per digit slot (DIV >= 4)
BLANK, 8, cycles at start of each slot with all enables off (1 <= BLANK < DIV)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous active-high reset
load_valid  input  1  new digit set offered
load_data  input  4*NDIG  BCD nibbles; bits [4k+3:4k] = digit k, digit 0 rightmost
load_ready  output  1  controller can accept load_data
data  output  4  BCD nibble to sevenseg decoder input
an  output  NDIG  one-hot digit enable, active-high
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- The interface uses one clock; reset is synchronous and active-high (clk, reset). The reset response happens on the next clk edge, including mid-frame.
- Reset state:
  - Slot counter cnt=0, digit index idx=0.
  - Shadow and active registers all 4'hF. Nibbles above 9 make the decoder blank.
  - pending=0, frame_done=0, load_ready=1.
  - an=0 (because cnt<BLANK) and data=4'hF.
- Any pending load is discarded on reset.
- cnt counts 0..DIV-1, then wraps to 0.
- On wrap, idx increments modulo NDIG: 0,1,...,NDIG-1,0.
- Output decode is combinational from registered cnt, idx and active.
  - data = active[idx].
  - an = one-hot(idx) when cnt >= BLANK, otherwise all zero.
  - Each digit is lit for DIV-BLANK cycles per slot. The frame period is NDIG*DIV cycles.
- Frame boundary: the edge where cnt==DIV-1 and idx==NDIG-1.
  - If pending=1, active <= shadow and pending <= 0.
  - frame_done is registered high for the one cycle following the boundary edge (cnt==0, idx==0). It pulses every frame, whether or not a commit occurred.
- Handshake:
  - load_ready = !pending.
  - A transfer occurs on an edge where load_valid && load_ready. shadow <= load_data and pending <= 1.
  - load_data may change freely when no transfer occurs. load_valid may be held across a not-ready period.
- Simultaneous events:
  - Transfer on the boundary edge with pending=0: shadow loads and pending sets, but no commit that edge. The commit happens at the next boundary, one frame later.
  - pending=1 at boundary: the commit clears pending, and load_ready is high in the cycle after the boundary.
- Non-BCD nibbles (A-F) pass through unchanged on data. The decoder blanks them.
- No arithmetic beyond counters. cnt width = clog2(DIV), idx width = clog2(NDIG) (minimum 1).

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: the output stage substitutes 4'hF on data for digit k (k >= 1) when active[k]==0 and every digit above k is also 0. Digit 0 is never blanked, so all-zero displays "0". Registers store unmodified values. an timing is unchanged.
- Undefined: data = active[idx] always, so leading zeros are displayed.

Test Plan:
All tests use NDIG=4, DIV=10, BLANK=2.
1. Reset held 3 cycles then released -> cycles 0-1 an=0000, data=F; cycles 2-9 an=0001, data=F; load_ready=1; frame_done first high at cycle 40.
2. Free-run 2 frames -> an sequence per slot: 2 cycles 0000 then 8 cycles of 0001/0010/0100/1000 in order; frame_done one-cycle pulses at cycles 40 and 80 only.
3. Load 16'h1234 at cycle 5 -> load_ready=0 from cycle 6; data stays F until the boundary; from cycle 40 data=4,3,2,1 in slots 0-3; load_ready=1 at cycle 40.
4. Load 16'h1234 at cycle 5, then hold load_valid with 16'h5678 -> second transfer on the cycle-40 edge, commit at cycle 80 (data 8,7,6,5); frame 40-79 shows 4,3,2,1.
5. Load with pending=0 exactly on boundary edge (cycle 39) -> frame 40-79 shows old values, new values from cycle 80. Separately, reset asserted at cycle 20 with a load pending -> pending cleared, active all F, load_ready=1.
6. With LEADING_ZERO_BLANK_EN: load 16'h0070 -> data per slot 0,7,F,F; load 16'h0000 -> 0,F,F,F. Without macro: 0,7,0,0 and 0,0,0,0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed scan controller for NDIG common-anode
// digits sharing one BCD-to-segment decoder. New digit sets are accepted into
// a shadow register and moved into the displayed (active) set only at a frame
// boundary, so a frame never mixes old and new digits. Each slot opens with
// BLANK cycles of all enables off to suppress ghosting.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (k >= 1) are replaced by 4'hF on data so
//   the decoder blanks them; digit 0 is always shown. Stored values are
//   unchanged and enable timing is unaffected.

module sevenseg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 1000,
    parameter int BLANK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [4*NDIG-1:0] load_data,
    output logic              load_ready,
    output logic [3:0]        data,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [4*NDIG-1:0] active_q, active_d;
    logic              pending_q, pending_d;
    logic              frame_done_q, frame_done_d;
    logic              boundary_s;
    logic [3:0]        nib_s;

    // Next-state logic: slot/digit counters, handshake capture and frame commit.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        boundary_s   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Commit and transfer are mutually exclusive: one needs pending set,
        // the other needs it clear. A transfer on the boundary edge therefore
        // waits a full frame for its commit.
        if (boundary_s) begin
            frame_done_d = 1'b1;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end else begin
                active_d = active_q;
            end
        end else begin
            frame_done_d = 1'b0;
        end

        if (load_valid && !pending_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end else begin
            shadow_d = shadow_d;
        end
    end

    // State registers with synchronous active-high reset; pending loads are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= {NDIG{4'hF}};
            active_q     <= {NDIG{4'hF}};
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0] zero_run_s;

    // zero_run_s[k] is set when digit k and every digit above it hold zero.
    always_comb begin
        zero_run_s         = '0;
        zero_run_s[NDIG-1] = (active_q[4*NDIG-1 -: 4] == 4'h0);
        for (int k = NDIG - 2; k >= 0; k--) begin
            zero_run_s[k] = zero_run_s[k+1] && (active_q[4*k +: 4] == 4'h0);
        end
    end

    // Output nibble: leading zeros above digit 0 become 4'hF (decoder blank).
    always_comb begin
        nib_s = active_q[{idx_q, 2'b00} +: 4];
        if ((idx_q != '0) && zero_run_s[idx_q]) begin
            data = 4'hF;
        end else begin
            data = nib_s;
        end
    end
`else
    // Output nibble: the active digit for the current slot, passed through as-is.
    always_comb begin
        nib_s = active_q[{idx_q, 2'b00} +: 4];
        data  = nib_s;
    end
`endif

    // Digit enable: one-hot on the current digit once the blanking gap has elapsed.
    always_comb begin
        an = '0;
        if (cnt_q >= CNT_BLANK) begin
            an[idx_q] = 1'b1;
        end else begin
            an = '0;
        end
    end

    assign load_ready = !pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (NDIG=4, DIV=10, BLANK=2).
// A time-based reference model predicts every cycle's outputs into a
// scoreboard queue; directed checks cover the key cycle numbers.
module tb_sevenseg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  data;
    logic [3:0]  an;
    logic        frame_done;

    sevenseg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .data       (data),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] an;
        logic       fd;
        logic       rdy;
    } obs_t;

    obs_t sb_q[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fd_count = 0;
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic obs_t model_expect();
        obs_t e;
        int   digit;
        int   phase;
        digit  = (t / DIV) % NDIG;
        phase  = t % DIV;
        e.an   = (phase >= BLANK) ? (4'b0001 << digit) : 4'b0000;
        e.data = m_active[digit*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (digit >= 1 && (m_active >> (4 * digit)) == 16'h0000) e.data = 4'hF;
`endif
        e.fd   = (t != 0) && (t % FRAME == 0);
        e.rdy  = !m_pending;
        return e;
    endfunction

    task automatic model_reset();
        t         = 0;
        m_active  = 16'hFFFF;
        m_shadow  = 16'hFFFF;
        m_pending = 1'b0;
    endtask

    // One cycle: predict, compare at negedge, then advance DUT and model one edge.
    task automatic cycle();
        obs_t e;
        obs_t got;
        logic commit;
        logic xfer;
        sb_q.push_back(model_expect());
        got.data = data;
        got.an   = an;
        got.fd   = frame_done;
        got.rdy  = load_ready;
        if (frame_done === 1'b1) fd_count++;
        e = sb_q.pop_front();
        chk_eq("sb_data", {28'd0, got.data}, {28'd0, e.data});
        chk_eq("sb_an", {28'd0, got.an}, {28'd0, e.an});
        chk_eq("sb_frame_done", {31'd0, got.fd}, {31'd0, e.fd});
        chk_eq("sb_load_ready", {31'd0, got.rdy}, {31'd0, e.rdy});
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            commit = (t % FRAME == FRAME - 1) && m_pending;
            xfer   = load_valid && !m_pending;
            if (commit) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (xfer) begin
                m_shadow  = load_data;
                m_pending = 1'b1;
            end
            t++;
        end
        @(negedge clk);
    endtask

    task automatic go(input int upto);
        while (t < upto) cycle();
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        load_valid = 1'b0;
        repeat (n) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_once(input logic [15:0] v);
        load_valid = 1'b1;
        load_data  = v;
        cycle();
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        t          = 0;

        // Reset state and two free-running frames.
        do_reset(3);
        chk_eq("rst_an", {28'd0, an}, 32'h0);
        chk_eq("rst_data", {28'd0, data}, 32'hF);
        chk_eq("rst_ready", {31'd0, load_ready}, 32'h1);
        chk_eq("rst_fd", {31'd0, frame_done}, 32'h0);
        go(2);  chk_eq("an_c2", {28'd0, an}, 32'h1);
        go(12); chk_eq("an_c12", {28'd0, an}, 32'h2);
        go(31); chk_eq("an_c31_blank", {28'd0, an}, 32'h0);
        go(32); chk_eq("an_c32", {28'd0, an}, 32'h8);
        go(40); chk_eq("fd_c40", {31'd0, frame_done}, 32'h1);
        go(81); chk_eq("fd_count", fd_count, 32'd2);

        // Load at cycle 5, then hold valid with a second value.
        do_reset(3);
        go(5);
        load_valid = 1'b1; load_data = 16'h1234;
        cycle();
        load_data = 16'h5678;
        chk_eq("ready_c6", {31'd0, load_ready}, 32'h0);
        go(39); chk_eq("data_c39", {28'd0, data}, 32'hF);
        go(40); chk_eq("ready_c40", {31'd0, load_ready}, 32'h1);
        chk_eq("data_c40", {28'd0, data}, 32'h4);
        cycle();
        load_valid = 1'b0;
        chk_eq("ready_c41", {31'd0, load_ready}, 32'h0);
        go(55);  chk_eq("data_c55", {28'd0, data}, 32'h3);
        go(75);  chk_eq("data_c75", {28'd0, data}, 32'h1);
        go(82);  chk_eq("data_c82", {28'd0, data}, 32'h8);
        go(115); chk_eq("data_c115", {28'd0, data}, 32'h5);

        // Transfer exactly on the boundary edge: commit one frame later.
        do_reset(3);
        go(39);
        load_once(16'h9876);
        chk_eq("bnd_data_c40", {28'd0, data}, 32'hF);
        chk_eq("bnd_ready_c40", {31'd0, load_ready}, 32'h0);
        go(79);  chk_eq("bnd_data_c79", {28'd0, data}, 32'hF);
        go(80);  chk_eq("bnd_data_c80", {28'd0, data}, 32'h6);
        go(110); chk_eq("bnd_data_c110", {28'd0, data}, 32'h9);

        // Reset mid-frame with a load pending.
        do_reset(2);
        go(5);
        load_once(16'h4321);
        go(20);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk_eq("mrst_ready", {31'd0, load_ready}, 32'h1);
        chk_eq("mrst_data", {28'd0, data}, 32'hF);
        chk_eq("mrst_an", {28'd0, an}, 32'h0);
        go(45); chk_eq("mrst_data_c45", {28'd0, data}, 32'hF);

        // Leading zeros.
        do_reset(2);
        go(5);
        load_once(16'h0070);
        go(40); chk_eq("lz_d0", {28'd0, data}, 32'h0);
        go(50); chk_eq("lz_d1", {28'd0, data}, 32'h7);
`ifdef LEADING_ZERO_BLANK_EN
        go(60); chk_eq("lz_d2", {28'd0, data}, 32'hF);
        go(70); chk_eq("lz_d3", {28'd0, data}, 32'hF);
`else
        go(60); chk_eq("lz_d2", {28'd0, data}, 32'h0);
        go(70); chk_eq("lz_d3", {28'd0, data}, 32'h0);
`endif
        go(75);
        load_once(16'h0000);
        go(80); chk_eq("lz0_d0", {28'd0, data}, 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
        go(90); chk_eq("lz0_d1", {28'd0, data}, 32'hF);
`else
        go(90); chk_eq("lz0_d1", {28'd0, data}, 32'h0);
`endif
        go(121);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
